// File: rtl/text_pkg.sv
// Shared types and constants for the text memory write controller.
package text_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_ESC = 8'h1B;
  localparam logic [7:0] PRINT_LO  = 8'h20;
  localparam logic [7:0] PRINT_HI  = 8'h7E;

  localparam int unsigned DEF_COLS  = 40;
  localparam int unsigned DEF_LINES = 15;

endpackage

// File: rtl/text_cursor.sv
// Hardware text cursor: column/line registers with wrap logic and linear address.
module text_cursor #(
  parameter int unsigned COLS   = 40,
  parameter int unsigned LINES  = 15,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              dec,
  input  logic              newline,
  input  logic              zero,
  output logic [5:0]        col,
  output logic [3:0]        line,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [5:0] COL_MAX  = 6'(COLS - 1);
  localparam logic [3:0] LINE_MAX = 4'(LINES - 1);

  logic [5:0] col_q, col_d;
  logic [3:0] line_q, line_d, line_next;

  // Line below, wrapping to the top since there is no scroll.
  assign line_next = (line_q == LINE_MAX) ? 4'd0 : line_q + 4'd1;

  always_comb begin
    col_d  = col_q;
    line_d = line_q;
    if (zero) begin
      col_d  = 6'd0;
      line_d = 4'd0;
    end else if (newline) begin
      col_d  = 6'd0;
      line_d = line_next;
    end else if (inc) begin
      if (col_q == COL_MAX) begin
        col_d  = 6'd0;
        line_d = line_next;
      end else begin
        col_d = col_q + 6'd1;
      end
    end else if (dec) begin
      if (col_q != 6'd0) begin
        col_d = col_q - 6'd1;
      end else if (line_q != 4'd0) begin
        col_d  = COL_MAX;
        line_d = line_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= 6'd0;
      line_q <= 4'd0;
    end else begin
      col_q  <= col_d;
      line_q <= line_d;
    end
  end

  assign col  = col_q;
  assign line = line_q;
  assign addr = ADDR_W'(line_q) * ADDR_W'(COLS) + ADDR_W'(col_q);

endmodule

// File: rtl/text_buffer_writer.sv
// Write-side controller for the 40x15 text memory: keyboard handshake, cursor
// editing (print, CR, BS) and full-screen clear, all outputs registered.
module text_buffer_writer
  import text_pkg::*;
#(
  parameter int unsigned       COLS           = DEF_COLS,
  parameter int unsigned       LINES          = DEF_LINES,
  parameter int unsigned       ADDR_W         = 10,
  parameter int unsigned       CHAR_W         = 8,
  parameter logic [CHAR_W-1:0] BLANK          = 8'h20,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  input  logic [CHAR_W-1:0] key_code,
  output logic              key_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [CHAR_W-1:0] wr_data,
  output logic [5:0]        cursor_col,
  output logic [3:0]        cursor_line,
  output logic              busy
);

  localparam logic [ADDR_W:0] CLR_LEN = (ADDR_W + 1)'(COLS * LINES);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
  logic              adv_q, adv_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [CHAR_W-1:0] wr_data_q, wr_data_d;
  logic              key_ready_q, key_ready_d;
  logic              busy_q, busy_d;

  logic              cur_inc, cur_dec, cur_newline, cur_zero;
  logic [ADDR_W-1:0] cur_addr;
  logic              accept, is_print, is_cr, is_bs, is_esc, at_origin;

  text_cursor #(
    .COLS   (COLS),
    .LINES  (LINES),
    .ADDR_W (ADDR_W)
  ) u_cursor (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (cur_inc),
    .dec     (cur_dec),
    .newline (cur_newline),
    .zero    (cur_zero),
    .col     (cursor_col),
    .line    (cursor_line),
    .addr    (cur_addr)
  );

  assign accept    = key_valid & key_ready_q;
  assign is_print  = (key_code >= PRINT_LO) && (key_code <= PRINT_HI);
  assign is_cr     = (key_code == ASCII_CR);
  assign is_bs     = (key_code == ASCII_BS);
  assign is_esc    = (key_code == ASCII_ESC);
  assign at_origin = (cursor_col == 6'd0) && (cursor_line == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_cnt_q   <= '0;
      adv_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= BLANK;
      key_ready_q <= !CLEAR_ON_RESET;
      busy_q      <= CLEAR_ON_RESET;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      adv_q       <= adv_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      key_ready_q <= key_ready_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_print || (is_bs && !at_origin)) begin
            state_d = WRITE;
          end else if (is_esc) begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
          end
        end
      end
      WRITE: state_d = IDLE;
      CLEAR: begin
        if (clr_cnt_q == CLR_LEN) state_d = IDLE;
        else                      clr_cnt_d = clr_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    adv_d       = adv_q;
    key_ready_d = (state_d == IDLE);
    busy_d      = (state_d == CLEAR);
    cur_inc     = 1'b0;
    cur_dec     = 1'b0;
    cur_newline = 1'b0;
    cur_zero    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_print) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cur_addr;
            wr_data_d = key_code;
            adv_d     = 1'b1;
          end else if (is_bs && !at_origin) begin
            // Backing up one cell is always linear address - 1, wrap included.
            cur_dec   = 1'b1;
            wr_en_d   = 1'b1;
            wr_addr_d = cur_addr - ADDR_W'(1);
            wr_data_d = BLANK;
            adv_d     = 1'b0;
          end else if (is_cr) begin
            cur_newline = 1'b1;
          end
        end
      end
      WRITE: cur_inc = adv_q;
      CLEAR: begin
        if (clr_cnt_q == CLR_LEN) begin
          cur_zero = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = clr_cnt_q[ADDR_W-1:0];
          wr_data_d = BLANK;
        end
      end
      default: ;
    endcase
  end

  assign key_ready = key_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_text_buffer_writer.sv
// Scoreboard bench for text_buffer_writer: expected writes are queued as keys are
// sent and checked whenever wr_en is seen; scenario tasks check cursor/handshake.
module tb_text_buffer_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ready;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] cursor_col;
  logic [3:0] cursor_line;
  logic       busy;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  text_buffer_writer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .cursor_col  (cursor_col),
    .cursor_line (cursor_line),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Scoreboard comparator: every observed write must match the oldest expectation.
  always @(negedge clk) begin
    if (wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got addr=%0d data=%h, required no write", wr_addr,
                 wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          failures++;
          $display("FAIL write got addr=%0d data=%h, required addr=%0d data=%h", wr_addr,
                   wr_data, e.addr, e.data);
        end
      end
    end
  end

  function automatic void push_wr(input int addr, input logic [7:0] data);
    wr_t e;
    e.addr = 10'(addr);
    e.data = data;
    exp_q.push_back(e);
  endfunction

  // Holds the code until accepted; returns at the negedge after the accept edge.
  task automatic send_key(input logic [7:0] code);
    int n = 0;
    key_valid = 1'b1;
    key_code  = code;
    while (!key_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL accept_timeout code=%h got key_ready=%b, required 1", code, key_ready);
    end
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic check_cursor(input string name, input int line, input int col);
    checks++;
    if (cursor_line !== 4'(line) || cursor_col !== 6'(col)) begin
      failures++;
      $display("FAIL %s cursor got (%0d,%0d), required (%0d,%0d)", name, cursor_line,
               cursor_col, line, col);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s pending writes got %0d, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (wr_en !== 1'b0 || wr_addr !== 10'd0 || wr_data !== 8'h20 || busy !== 1'b1 ||
        key_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s got wr_en=%b wr_addr=%0d wr_data=%h busy=%b key_ready=%b, required 0 0 20 1 0",
               name, wr_en, wr_addr, wr_data, busy, key_ready);
    end
    check_cursor(name, 0, 0);
  endtask

  // Counts busy cycles after release; clear writes go through the scoreboard.
  task automatic wait_clear(input string name, input int expected);
    int n = 0;
    int ready_seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) break;
      if (key_ready) ready_seen++;
      n++;
    end
    checks++;
    if (n != expected) begin
      failures++;
      $display("FAIL %s busy_cycles got %0d, required %0d", name, n, expected);
    end
    checks++;
    if (ready_seen != 0) begin
      failures++;
      $display("FAIL %s key_ready_during_clear got %0d cycles, required 0", name, ready_seen);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    for (int i = 0; i < 600; i++) push_wr(i, 8'h20);
    rst_n = 1'b1;
    wait_clear("power_on_clear", 600);
    checks++;
    if (key_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_clear key_ready got %b, required 1", key_ready);
    end
    check_cursor("post_clear", 0, 0);
    check_drained("post_clear");
  endtask

  task automatic test_print();
    push_wr(0, 8'h41);
    push_wr(1, 8'h42);
    send_key(8'h41);
    checks++;
    if (key_ready !== 1'b0 || wr_en !== 1'b1) begin
      failures++;
      $display("FAIL write_A_cycle got key_ready=%b wr_en=%b, required 0 1", key_ready, wr_en);
    end
    send_key(8'h42);
    checks++;
    if (key_ready !== 1'b0) begin
      failures++;
      $display("FAIL write_B_cycle got key_ready=%b, required 0", key_ready);
    end
    @(negedge clk);
    check_cursor("print_AB", 0, 2);
    check_drained("print_AB");
  endtask

  task automatic test_wrap();
    repeat (3) send_key(8'h0D);
    for (int i = 0; i < 39; i++) begin
      push_wr(120 + i, 8'h61);
      send_key(8'h61);
    end
    @(negedge clk);
    check_cursor("fill_line3", 3, 39);
    push_wr(159, 8'h5A);
    send_key(8'h5A);
    @(negedge clk);
    check_cursor("wrap_col", 4, 0);
    repeat (10) send_key(8'h0D);
    for (int i = 0; i < 39; i++) begin
      push_wr(560 + i, 8'h62);
      send_key(8'h62);
    end
    @(negedge clk);
    check_cursor("fill_line14", 14, 39);
    push_wr(599, 8'h5A);
    send_key(8'h5A);
    @(negedge clk);
    check_cursor("wrap_screen", 0, 0);
    check_drained("wrap");
  endtask

  task automatic test_cr();
    repeat (2) send_key(8'h0D);
    for (int i = 0; i < 5; i++) begin
      push_wr(80 + i, 8'h30 + 8'(i));
      send_key(8'h30 + 8'(i));
    end
    @(negedge clk);
    check_cursor("before_cr", 2, 5);
    send_key(8'h0D);
    checks++;
    if (key_ready !== 1'b1 || wr_en !== 1'b0) begin
      failures++;
      $display("FAIL cr got key_ready=%b wr_en=%b, required 1 0", key_ready, wr_en);
    end
    check_cursor("cr", 3, 0);
    check_drained("cr");
  endtask

  task automatic test_bs();
    repeat (13) send_key(8'h0D);
    check_cursor("before_bs", 1, 0);
    push_wr(39, 8'h20);
    send_key(8'h08);
    check_cursor("bs_wrap", 0, 39);
    @(negedge clk);
    check_drained("bs_wrap");
    for (int i = 38; i >= 0; i--) begin
      push_wr(i, 8'h20);
      send_key(8'h08);
    end
    @(negedge clk);
    check_cursor("bs_to_origin", 0, 0);
    check_drained("bs_to_origin");
    send_key(8'h08);
    checks++;
    if (wr_en !== 1'b0 || key_ready !== 1'b1) begin
      failures++;
      $display("FAIL bs_at_origin got wr_en=%b key_ready=%b, required 0 1", wr_en, key_ready);
    end
    check_cursor("bs_at_origin", 0, 0);
    send_key(8'h07);
    @(negedge clk);
    check_cursor("ignored_code", 0, 0);
  endtask

  task automatic test_esc_reset();
    int n = 0;
    for (int i = 0; i < 600; i++) push_wr(i, 8'h20);
    send_key(8'h1B);
    checks++;
    if (busy !== 1'b1 || key_ready !== 1'b0) begin
      failures++;
      $display("FAIL esc_enter got busy=%b key_ready=%b, required 1 0", busy, key_ready);
    end
    while (!(wr_en && wr_addr == 10'd300) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL clear_reach_300 got timeout, required address 300");
    end
    #2 rst_n = 1'b0;
    #1 check_reset_values("reset_mid_clear");
    exp_q.delete();
    key_valid = 1'b1;
    key_code  = 8'h51;
    @(negedge clk);
    for (int i = 0; i < 600; i++) push_wr(i, 8'h20);
    rst_n = 1'b1;
    wait_clear("restart_clear", 600);
    check_drained("restart_clear");
    push_wr(0, 8'h51);
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    check_cursor("held_key", 0, 1);
    check_drained("held_key");
  endtask

  initial begin
    test_reset();
    test_print();
    test_wrap();
    test_cr();
    test_bs();
    test_esc_reset();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
